// File: rtl/kernel_scheduler_pkg.sv
// Shared types and constants for the kernel scheduler: state encoding,
// counter widths and the read-port values driven while the host is locked out.
package kernel_scheduler_pkg;

  localparam int CNT_W = 16;
  localparam int CYC_W = 32;

  localparam logic [CNT_W-1:0] IDLE_TENSOR_ID = 16'hFFFF;
  localparam logic [CNT_W-1:0] IDLE_INDEX     = 16'h0000;

  typedef enum logic [2:0] {
    IDLE,
    ISSUE,
    WAIT,
    NEXT,
    DONE,
    ABORT
  } state_e;

endpackage

// File: rtl/kernel_watchdog.sv
// Per-kernel watchdog: cleared on issue, counts while waiting, flags expiry
// in the cycle its count reaches TIMEOUT.
module kernel_watchdog
  import kernel_scheduler_pkg::*;
#(
  parameter int TIMEOUT = 65535
) (
  input  logic clock,
  input  logic reset,
  input  logic clr,
  input  logic en,
  output logic expired
);

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [CNT_W:0]   cnt_inc;

  // One extra bit so TIMEOUT=65535 compares without wrapping.
  assign cnt_inc = {1'b0, cnt_q} + (CNT_W+1)'(1);
  assign expired = en & (cnt_inc >= (CNT_W+1)'(TIMEOUT));

  always_comb begin
    cnt_d = cnt_q;
    if (clr)     cnt_d = '0;
    else if (en) cnt_d = cnt_inc[CNT_W-1:0];
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) cnt_q <= '0;
    else       cnt_q <= cnt_d;
  end

endmodule

// File: rtl/kernel_scheduler.sv
// Issues kernel targets to the compute core for a number of passes, with a
// watchdog abort, and arbitrates the core's tensor read port to the host.
module kernel_scheduler
  import kernel_scheduler_pkg::*;
#(
  parameter int NUM_TARGETS = 2,
  parameter int TIMEOUT     = 65535
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             run_req,
  input  logic [CNT_W-1:0] iterations,
  output logic             busy,
  output logic             done,
  output logic             error,
  output logic [CYC_W-1:0] cycle_count,
  output logic             core_start,
  output logic [CNT_W-1:0] core_target,
  input  logic             core_done,
  output logic [CNT_W-1:0] core_read_tensor_id,
  output logic [CNT_W-1:0] core_read_index,
  input  logic [CNT_W-1:0] core_read_data,
  input  logic             host_read_valid,
  output logic             host_read_ready,
  input  logic [CNT_W-1:0] host_tensor_id,
  input  logic [CNT_W-1:0] host_index,
  output logic [CNT_W-1:0] host_data,
  output logic             host_data_valid
);

  state_e           state_q, state_d;
  logic [CNT_W-1:0] target_q, target_d;
  logic [CNT_W-1:0] pass_q, pass_d;
  logic [CNT_W-1:0] passes_q, passes_d;
  logic             error_q, error_d;
  logic [CYC_W-1:0] cyc_q, cyc_d;
  logic [CYC_W-1:0] cycle_count_q, cycle_count_d;
  logic [CNT_W-1:0] host_data_q, host_data_d;
  logic             host_data_valid_q, host_data_valid_d;
  logic             wd_expired;
  logic             read_fire;

  kernel_watchdog #(.TIMEOUT(TIMEOUT)) u_watchdog (
    .clock   (clock),
    .reset   (reset),
    .clr     (state_q == ISSUE),
    .en      (state_q == WAIT),
    .expired (wd_expired)
  );

  assign busy        = (state_q != IDLE);
  assign done        = (state_q == DONE) || (state_q == ABORT);
  assign error       = error_q;
  assign cycle_count = cycle_count_q;
  assign core_start  = (state_q == ISSUE);
  assign core_target = target_q;

  // A run request in the same cycle takes the port away from the host.
  assign host_read_ready     = (state_q == IDLE) & ~run_req;
  assign core_read_tensor_id = host_read_ready ? host_tensor_id : IDLE_TENSOR_ID;
  assign core_read_index     = host_read_ready ? host_index     : IDLE_INDEX;
  assign read_fire           = host_read_valid & host_read_ready;
  assign host_data           = host_data_q;
  assign host_data_valid     = host_data_valid_q;

  always_comb begin
    host_data_d       = read_fire ? core_read_data : host_data_q;
    host_data_valid_d = read_fire;
  end

  always_comb begin
    state_d       = state_q;
    target_d      = target_q;
    pass_d        = pass_q;
    passes_d      = passes_q;
    error_d       = error_q;
    cyc_d         = cyc_q;
    cycle_count_d = cycle_count_q;

    // Run-length counter reads 1 after the first ISSUE cycle, so the value
    // captured in DONE/ABORT is the number of cycles before completion.
    if (state_q != IDLE && cyc_q != '1) cyc_d = cyc_q + CYC_W'(1);

    unique case (state_q)
      IDLE: begin
        if (run_req) begin
          state_d  = ISSUE;
          target_d = '0;
          pass_d   = '0;
          cyc_d    = '0;
          error_d  = 1'b0;
          passes_d = (iterations == '0) ? CNT_W'(1) : iterations;
        end
      end
      ISSUE: state_d = WAIT;
      WAIT: begin
        if (core_done) begin
          state_d = NEXT;
        end else if (wd_expired) begin
          state_d = ABORT;
          error_d = 1'b1;
        end
      end
      NEXT: begin
        if (target_q < CNT_W'(NUM_TARGETS - 1)) begin
          target_d = target_q + CNT_W'(1);
          state_d  = ISSUE;
        end else if (pass_q < passes_q - CNT_W'(1)) begin
          target_d = '0;
          pass_d   = pass_q + CNT_W'(1);
          state_d  = ISSUE;
        end else begin
          state_d = DONE;
        end
      end
      DONE, ABORT: begin
        cycle_count_d = cyc_q;
        state_d       = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q           <= IDLE;
      target_q          <= '0;
      pass_q            <= '0;
      passes_q          <= CNT_W'(1);
      error_q           <= 1'b0;
      cyc_q             <= '0;
      cycle_count_q     <= '0;
      host_data_q       <= '0;
      host_data_valid_q <= 1'b0;
    end else begin
      state_q           <= state_d;
      target_q          <= target_d;
      pass_q            <= pass_d;
      passes_q          <= passes_d;
      error_q           <= error_d;
      cyc_q             <= cyc_d;
      cycle_count_q     <= cycle_count_d;
      host_data_q       <= host_data_d;
      host_data_valid_q <= host_data_valid_d;
    end
  end

endmodule

// File: tb/tb_kernel_scheduler.sv
// Directed bench for kernel_scheduler: table of run vectors with a built-in
// core responder, plus hand sequences for reset, host reads and mid-run reset.
module tb_kernel_scheduler;

  logic        clock = 1'b0;
  logic        reset;
  logic        run_req;
  logic [15:0] iterations;
  logic        busy, done, error;
  logic [31:0] cycle_count;
  logic        core_start;
  logic [15:0] core_target;
  logic        core_done;
  logic [15:0] core_read_tensor_id, core_read_index, core_read_data;
  logic        host_read_valid, host_read_ready;
  logic [15:0] host_tensor_id, host_index, host_data;
  logic        host_data_valid;

  kernel_scheduler #(.NUM_TARGETS(2), .TIMEOUT(4)) dut (
    .clock               (clock),
    .reset               (reset),
    .run_req             (run_req),
    .iterations          (iterations),
    .busy                (busy),
    .done                (done),
    .error               (error),
    .cycle_count         (cycle_count),
    .core_start          (core_start),
    .core_target         (core_target),
    .core_done           (core_done),
    .core_read_tensor_id (core_read_tensor_id),
    .core_read_index     (core_read_index),
    .core_read_data      (core_read_data),
    .host_read_valid     (host_read_valid),
    .host_read_ready     (host_read_ready),
    .host_tensor_id      (host_tensor_id),
    .host_index          (host_index),
    .host_data           (host_data),
    .host_data_valid     (host_data_valid)
  );

  always #5 clock = ~clock;

  // Tiny combinational core memory: tensor 0 index 2 holds 0x0500.
  assign core_read_data = (core_read_tensor_id == 16'd0 && core_read_index == 16'd2) ?
                          16'h0500 : {core_read_tensor_id[7:0], core_read_index[7:0]};

  typedef struct {
    logic [15:0] iters;
    int          dly;      // cycles from core_start to core_done; 0 = never answer
    int          kernels;
    int          cc;
    int          offset;   // cycles from run_req to done pulse
    logic        err;
    logic        collide;  // host read in the same cycle as run_req
  } vec_t;

  vec_t vecs[7];
  int   total = 0;
  int   bad   = 0;
  logic prev_err = 1'b0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic run_vec(input vec_t v);
    int cd = 0;
    int starts = 0;
    int done_at = -1;
    int done_cnt = 0;
    @(negedge clock);
    chk("error_sticky_before_run", error, prev_err);
    run_req         = 1'b1;
    iterations      = v.iters;
    host_read_valid = v.collide;
    host_tensor_id  = 16'd3;
    host_index      = 16'd4;
    #1;
    if (v.collide) chk("collide_ready_low", host_read_ready, 1'b0);
    for (int k = 1; k <= 80; k++) begin
      @(negedge clock);
      if (k == 1) begin
        run_req         = 1'b0;
        host_read_valid = 1'b0;
        iterations      = 16'd7;
        chk("first_start_latency", core_start, 1'b1);
        chk("error_cleared_on_run", error, 1'b0);
        chk("no_host_valid_in_run", host_data_valid, 1'b0);
        chk("host_data_held", host_data, 16'h0500);
      end
      if (k == 2) begin
        chk("ready_low_in_run", host_read_ready, 1'b0);
        chk("idle_tensor_id", core_read_tensor_id, 16'hFFFF);
        chk("idle_index", core_read_index, 16'h0000);
        chk("busy_in_run", busy, 1'b1);
      end
      run_req = (k == 3);
      if (done) begin
        done_cnt++;
        if (done_at < 0) begin
          done_at = k;
          chk("error_at_done", error, v.err);
        end
      end
      if (done_at >= 0 && k == done_at + 1) begin
        chk("cycle_count", cycle_count, v.cc);
        chk("busy_after_done", busy, 1'b0);
      end
      core_done = 1'b0;
      if (core_start) begin
        chk("target_seq", core_target, starts % 2);
        starts++;
        cd = v.dly;
      end else if (cd > 0) begin
        cd--;
        if (cd == 0) core_done = 1'b1;
      end
      if (done_at >= 0 && k >= done_at + 3) break;
    end
    core_done = 1'b0;
    run_req   = 1'b0;
    chk("done_latency", done_at, v.offset);
    chk("done_once", done_cnt, 1);
    chk("start_count", starts, v.kernels);
    prev_err = v.err;
  endtask

  initial begin
    #1000000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1, "bench timeout");
  end

  initial begin
    int dn;
    vecs[0] = '{16'd1, 3, 2, 10, 11, 1'b0, 1'b0};
    vecs[1] = '{16'd0, 3, 2, 10, 11, 1'b0, 1'b0};
    vecs[2] = '{16'd3, 3, 6, 30, 31, 1'b0, 1'b0};
    vecs[3] = '{16'd1, 4, 2, 12, 13, 1'b0, 1'b0};  // done coincides with watchdog limit
    vecs[4] = '{16'd1, 0, 1,  5,  6, 1'b1, 1'b0};  // core never answers
    vecs[5] = '{16'd2, 1, 4, 12, 13, 1'b0, 1'b0};
    vecs[6] = '{16'd1, 2, 2,  8,  9, 1'b0, 1'b1};

    reset = 1'b1; run_req = 1'b0; iterations = 16'd0; core_done = 1'b0;
    host_read_valid = 1'b0; host_tensor_id = 16'd5; host_index = 16'd6;
    @(negedge clock); @(negedge clock);
    chk("rst_busy", busy, 1'b0);
    chk("rst_done", done, 1'b0);
    chk("rst_error", error, 1'b0);
    chk("rst_cycle_count", cycle_count, 32'd0);
    chk("rst_core_start", core_start, 1'b0);
    chk("rst_core_target", core_target, 16'd0);
    chk("rst_host_data", host_data, 16'd0);
    chk("rst_host_data_valid", host_data_valid, 1'b0);
    reset = 1'b0;
    #1;
    chk("rst_ready", host_read_ready, 1'b1);
    chk("rst_passthru_id", core_read_tensor_id, 16'd5);
    chk("rst_passthru_idx", core_read_index, 16'd6);

    // Host read in IDLE.
    @(negedge clock);
    host_read_valid = 1'b1; host_tensor_id = 16'd0; host_index = 16'd2;
    #1;
    chk("read_ready", host_read_ready, 1'b1);
    chk("read_passthru_id", core_read_tensor_id, 16'd0);
    chk("read_passthru_idx", core_read_index, 16'd2);
    @(negedge clock);
    host_read_valid = 1'b0;
    chk("read_valid_pulse", host_data_valid, 1'b1);
    chk("read_data", host_data, 16'h0500);
    @(negedge clock);
    chk("read_valid_drop", host_data_valid, 1'b0);
    chk("read_data_hold", host_data, 16'h0500);

    // core_done outside WAIT is ignored.
    core_done = 1'b1;
    @(negedge clock);
    core_done = 1'b0;
    chk("stray_core_done", busy, 1'b0);

    for (int i = 0; i < 7; i++) run_vec(vecs[i]);

    // Reset while waiting on the core: busy drops at once, no done follows.
    @(negedge clock);
    run_req = 1'b1; iterations = 16'd1;
    @(negedge clock);
    run_req = 1'b0;
    @(negedge clock);
    chk("pre_reset_busy", busy, 1'b1);
    reset = 1'b1;
    #1;
    chk("midrun_reset_busy", busy, 1'b0);
    chk("midrun_reset_done", done, 1'b0);
    chk("midrun_reset_start", core_start, 1'b0);
    @(negedge clock);
    reset = 1'b0;
    dn = 0;
    for (int k = 0; k < 8; k++) begin
      @(negedge clock);
      if (done) dn++;
    end
    chk("midrun_reset_no_done", dn, 0);
    chk("midrun_reset_idle", busy, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
